// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register; 32-bit ALU (add/sub/and/or).
// Define EX_MUL_EN to add the iterative shift-add multiplier (code 1000) with upstream stall.
module ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] val1_i,
  input  logic [31:0] val2_i,
  input  logic [31:0] store_data_i,
  input  logic [3:0]  alu_ctrl_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [1:0]  mem_i,
  input  logic        wb_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  rd_addr_o,
  output logic [1:0]  mem_o,
  output logic        wb_o
);

  logic [31:0] aluResult;
  logic        load;
  logic [31:0] loadResult;
  logic        stallRaw;

  logic        valid_q;
  logic [31:0] result_q;
  logic [31:0] storeData_q;
  logic [4:0]  rdAddr_q;
  logic [1:0]  mem_q;
  logic        wb_q;

  always_comb begin
    aluResult = 32'd0;
    case (alu_ctrl_i)
      4'b0010: aluResult = val1_i + val2_i;
      4'b0110: aluResult = val1_i - val2_i;
      4'b0000: aluResult = val1_i & val2_i;
      4'b0001: aluResult = val1_i | val2_i;
      default: aluResult = 32'd0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic        isMul;
  logic [31:0] accStep;

  assign isMul   = (alu_ctrl_i == 4'b1000);
  // Accumulator value after this cycle's iteration; also the final product on the last one.
  assign accStep = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    load       = 1'b0;
    loadResult = aluResult;
    stallRaw   = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end else if (state_q == IDLE) begin
      if (valid_i && isMul) begin
        state_d  = BUSY;
        cnt_d    = 5'd0;
        mcand_d  = val1_i;
        mplier_d = val2_i;
        acc_d    = 32'd0;
        stallRaw = 1'b1;
      end else if (valid_i) begin
        load = 1'b1;
      end
    end else begin
      acc_d    = accStep;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        load       = 1'b1;
        loadResult = accStep;
        state_d    = IDLE;
      end else begin
        stallRaw = 1'b1;
      end
    end
  end
`else
  always_comb begin
    load       = valid_i & ~flush_i;
    loadResult = aluResult;
    stallRaw   = 1'b0;
  end
`endif

  assign stall_o = stallRaw & ~rst_i;

  // Bubbles clear the side-effect bits but leave data fields untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= 1'b0;
      result_q    <= 32'd0;
      storeData_q <= 32'd0;
      rdAddr_q    <= 5'd0;
      mem_q       <= 2'b00;
      wb_q        <= 1'b0;
    end else begin
      valid_q <= load;
      mem_q   <= load ? mem_i : 2'b00;
      wb_q    <= load & wb_i;
      if (load) begin
        result_q    <= loadResult;
        storeData_q <= store_data_i;
        rdAddr_q    <= rd_addr_i;
      end
    end
  end

  assign valid_o      = valid_q;
  assign alu_result_o = result_q;
  assign store_data_o = storeData_q;
  assign rd_addr_o    = rdAddr_q;
  assign mem_o        = mem_q;
  assign wb_o         = wb_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage; expectations adapt to whether EX_MUL_EN is defined.
module tb_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        flush_i;
  logic [31:0] val1_i;
  logic [31:0] val2_i;
  logic [31:0] store_data_i;
  logic [3:0]  alu_ctrl_i;
  logic [4:0]  rd_addr_i;
  logic [1:0]  mem_i;
  logic        wb_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] alu_result_o;
  logic [31:0] store_data_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  mem_o;
  logic        wb_o;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b1000;

  ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .val1_i(val1_i), .val2_i(val2_i), .store_data_i(store_data_i),
    .alu_ctrl_i(alu_ctrl_i), .rd_addr_i(rd_addr_i), .mem_i(mem_i), .wb_i(wb_i),
    .stall_o(stall_o), .valid_o(valid_o), .alu_result_o(alu_result_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .mem_o(mem_o), .wb_o(wb_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic [1:0] m, input logic w);
    valid_i      = v;
    alu_ctrl_i   = op;
    val1_i       = a;
    val2_i       = b;
    store_data_i = a ^ 32'hA5A5_0000;
    rd_addr_i    = rd;
    mem_i        = m;
    wb_i         = w;
  endtask

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a mul, counts stall cycles and bubbles, then checks the result.
  task automatic runMul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expected);
    int stallCount = 0;
    int bubbles    = 0;
    applyStimulus(1'b1, OP_MUL, a, b, 5'd9, 2'b00, 1'b1);
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!stall_o) break;
      stallCount++;
      stepCycle();
      if (!valid_o && !wb_o) bubbles++;
    end
    checkOutput({tag, "_stallCycles"}, stallCount, 32);
    checkOutput({tag, "_bubbles"}, bubbles, 32);
    stepCycle();
    checkOutput({tag, "_valid"}, valid_o, 1);
    checkOutput({tag, "_result"}, alu_result_o, expected);
    checkOutput({tag, "_rd"}, rd_addr_o, 9);
    checkOutput({tag, "_storeData"}, store_data_o, a ^ 32'hA5A5_0000);
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    applyStimulus(1'b0, OP_ADD, 0, 0, 0, 2'b00, 1'b0);
    #1;
    checkOutput("reset_valid", valid_o, 0);
    checkOutput("reset_result", alu_result_o, 0);
    checkOutput("reset_stall", stall_o, 0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset asserted while a live instruction sits in EX/MEM
    applyStimulus(1'b1, OP_ADD, 32'd20, 32'd22, 5'd3, 2'b01, 1'b1);
    stepCycle();
    checkOutput("pre_reset_valid", valid_o, 1);
    checkOutput("pre_reset_result", alu_result_o, 42);
    applyStimulus(1'b1, OP_MUL, 32'd2, 32'd3, 5'd4, 2'b00, 1'b1);
    rst_i = 1'b1;
    #1;
    checkOutput("midreset_valid", valid_o, 0);
    checkOutput("midreset_result", alu_result_o, 0);
    checkOutput("midreset_rd", rd_addr_o, 0);
    checkOutput("midreset_mem", mem_o, 0);
    checkOutput("midreset_wb", wb_o, 0);
    checkOutput("midreset_stall", stall_o, 0);
    stepCycle();
    rst_i = 1'b0;
    applyStimulus(1'b0, OP_ADD, 0, 0, 0, 2'b00, 1'b0);
    stepCycle();

    // Back-to-back ALU ops
    applyStimulus(1'b1, OP_ADD, 32'd5, 32'd7, 5'd1, 2'b00, 1'b1);
    stepCycle();
    checkOutput("add_result", alu_result_o, 32'd12);
    checkOutput("add_rd", rd_addr_o, 1);
    checkOutput("add_wb", wb_o, 1);
    checkOutput("add_storeData", store_data_o, 32'hA5A5_0005);
    applyStimulus(1'b1, OP_SUB, 32'd3, 32'd5, 5'd2, 2'b10, 1'b1);
    stepCycle();
    checkOutput("sub_result", alu_result_o, 32'hFFFF_FFFE);
    checkOutput("sub_mem", mem_o, 2'b10);
    applyStimulus(1'b1, OP_AND, 32'hF0F0, 32'hFF00, 5'd5, 2'b01, 1'b0);
    stepCycle();
    checkOutput("and_result", alu_result_o, 32'hF000);
    checkOutput("and_mem", mem_o, 2'b01);
    checkOutput("and_wb", wb_o, 0);
    applyStimulus(1'b1, OP_OR, 32'h0F, 32'hF0, 5'd31, 2'b00, 1'b1);
    stepCycle();
    checkOutput("or_result", alu_result_o, 32'hFF);
    checkOutput("or_rd", rd_addr_o, 31);
    checkOutput("or_valid", valid_o, 1);

    // Bubble forces side-effect bits low
    applyStimulus(1'b0, OP_ADD, 32'd1, 32'd1, 5'd7, 2'b11, 1'b1);
    stepCycle();
    checkOutput("bubble_valid", valid_o, 0);
    checkOutput("bubble_mem", mem_o, 0);
    checkOutput("bubble_wb", wb_o, 0);

    // Undefined code
    applyStimulus(1'b1, 4'b0111, 32'd9, 32'd9, 5'd6, 2'b00, 1'b1);
    stepCycle();
    checkOutput("undef_result", alu_result_o, 0);
    checkOutput("undef_valid", valid_o, 1);

    // Flush kills a plain ALU op
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd2, 5'd8, 2'b01, 1'b1);
    flush_i = 1'b1;
    stepCycle();
    flush_i = 1'b0;
    checkOutput("flushAlu_valid", valid_o, 0);
    checkOutput("flushAlu_mem", mem_o, 0);

`ifdef EX_MUL_EN
    runMul("mulNeg", 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    runMul("mulBig", 32'd12345, 32'd678, 32'd8369910);
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, 5'd10, 2'b00, 1'b1);
    #1;
    checkOutput("afterMul_stall", stall_o, 0);
    stepCycle();
    checkOutput("afterMul_result", alu_result_o, 2);
    checkOutput("afterMul_valid", valid_o, 1);

    // Flush while BUSY with cnt==10
    applyStimulus(1'b1, OP_MUL, 32'd5, 32'd5, 5'd11, 2'b00, 1'b1);
    for (int i = 0; i < 11; i++) stepCycle();
    checkOutput("busy_stall", stall_o, 1);
    flush_i = 1'b1;
    #1;
    checkOutput("flushBusy_stall", stall_o, 0);
    stepCycle();
    flush_i = 1'b0;
    checkOutput("flushBusy_valid", valid_o, 0);
    checkOutput("flushBusy_wb", wb_o, 0);
    applyStimulus(1'b1, OP_ADD, 32'd4, 32'd4, 5'd12, 2'b00, 1'b1);
    #1;
    checkOutput("postFlush_stall", stall_o, 0);
    stepCycle();
    checkOutput("postFlush_result", alu_result_o, 8);
    checkOutput("postFlush_valid", valid_o, 1);
`else
    applyStimulus(1'b1, OP_MUL, 32'd6, 32'd7, 5'd13, 2'b00, 1'b1);
    #1;
    checkOutput("noMul_stall", stall_o, 0);
    stepCycle();
    checkOutput("noMul_result", alu_result_o, 0);
    checkOutput("noMul_valid", valid_o, 1);
    checkOutput("noMul_rd", rd_addr_o, 13);
`endif

    applyStimulus(1'b0, OP_ADD, 0, 0, 0, 2'b00, 1'b0);
    stepCycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
